// File: rtl/lcd_text_ctrl.sv
// HD44780-style 8-bit text LCD controller: power-up init sequence, then refreshes
// a ROWS x COLS character buffer to the panel, one SETUP/PULSE/HOLD transfer per byte.
module lcd_text_ctrl #(
  parameter int COLS    = 16,
  parameter int ROWS    = 2,
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_CMD   = 40,
  parameter int T_LONG  = 1600,
  parameter int AUTO    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_row,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_data,
  input  logic       refresh_req,
  output logic       busy,
  output logic       init_done,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  localparam int TM1  = (T_LONG > T_CMD) ? T_LONG : T_CMD;
  localparam int TM2  = (T_PULSE > T_SETUP) ? T_PULSE : T_SETUP;
  localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_FUNC, S_DISP, S_ENTRY, S_CLR, S_IDLE, S_ADDR, S_DATA
  } state_t;
  typedef enum logic [1:0] {P_SETUP, P_PULSE, P_HOLD} phase_t;

  state_t          state, nstate;
  phase_t          phase, nphase;
  logic [CW-1:0]   cnt, ncnt, limit;
  logic [1:0]      row, nrow;
  logic [5:0]      col, ncol;
  logic            pending, npend, done, start, clr;
  logic            e_d, rs_d;
  logic [7:0]      data_d, rd_char;
  logic [7:0]      mem [ROWS][COLS];

  function automatic logic [7:0] addr_cmd(input logic [1:0] r);
    case (r)
      2'd0:    return 8'h80;
      2'd1:    return 8'hC0;
      2'd2:    return 8'h94;
      default: return 8'hD4;
    endcase
  endfunction

  // Buffer is filled with spaces on the first power-up cycle; a user write wins.
  assign clr = (state == S_PWRUP) && (cnt == '0);

  always_ff @(posedge clk)
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (wr_en && wr_row == r[1:0] && wr_col == c[5:0]) mem[r][c] <= wr_data;
        else if (clr)                                     mem[r][c] <= 8'h20;

  // Character for the transfer about to start, looked up at its own start.
  always_comb begin
    rd_char = 8'h20;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (nrow == r[1:0] && ncol == c[5:0]) rd_char = mem[r][c];
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= S_PWRUP;
      phase     <= P_SETUP;
      cnt       <= '0;
      row       <= '0;
      col       <= '0;
      pending   <= 1'b0;
      init_done <= 1'b0;
      LCD_E     <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_DATA  <= 8'h00;
    end else begin
      state     <= nstate;
      phase     <= nphase;
      cnt       <= ncnt;
      row       <= nrow;
      col       <= ncol;
      pending   <= npend;
      init_done <= init_done | (nstate == S_IDLE);
      LCD_E     <= e_d;
      LCD_RS    <= rs_d;
      LCD_DATA  <= data_d;
    end

  always_comb begin
    nstate = state;
    nphase = phase;
    ncnt   = cnt + 1'b1;
    nrow   = row;
    ncol   = col;
    start  = 1'b0;
    npend  = pending;
    case (phase)
      P_PULSE: limit = CW'(T_PULSE);
      P_HOLD:  limit = (state == S_CLR) ? CW'(T_LONG) : CW'(T_CMD);
      default: limit = CW'(T_SETUP);
    endcase
    if (state == S_PWRUP) limit = CW'(T_LONG);
    done = (cnt == limit - 1'b1);

    case (state)
      S_PWRUP:
        if (done) begin
          nstate = S_FUNC;
          nphase = P_SETUP;
          ncnt   = '0;
          start  = 1'b1;
        end
      S_IDLE: begin
        ncnt  = '0;
        npend = 1'b0;
        if (AUTO != 0 || pending || refresh_req) begin
          nstate = S_ADDR;
          nphase = P_SETUP;
          nrow   = '0;
          ncol   = '0;
          start  = 1'b1;
        end
      end
      default:
        if (done) begin
          ncnt = '0;
          case (phase)
            P_SETUP: nphase = P_PULSE;
            P_PULSE: nphase = P_HOLD;
            default: begin
              nphase = P_SETUP;
              start  = 1'b1;
              case (state)
                S_FUNC:  nstate = S_DISP;
                S_DISP:  nstate = S_ENTRY;
                S_ENTRY: nstate = S_CLR;
                S_CLR: begin
                  nstate = S_IDLE;
                  start  = 1'b0;
                end
                S_ADDR:  nstate = S_DATA;
                default:
                  if (col == 6'(COLS - 1)) begin
                    ncol = '0;
                    if (row == 2'(ROWS - 1)) begin
                      nrow   = '0;
                      nstate = S_IDLE;
                      start  = 1'b0;
                    end else begin
                      nrow   = row + 1'b1;
                      nstate = S_ADDR;
                    end
                  end else begin
                    ncol = col + 1'b1;
                  end
              endcase
            end
          endcase
        end
    endcase

    // A request seen mid-refresh is remembered once and replayed from IDLE.
    if (state != S_IDLE && refresh_req && init_done) npend = 1'b1;
  end

  always_comb begin
    busy   = (state != S_IDLE);
    LCD_RW = 1'b0;
    e_d    = (nphase == P_PULSE);
    rs_d   = LCD_RS;
    data_d = LCD_DATA;
    if (start)
      case (nstate)
        S_FUNC:  begin rs_d = 1'b0; data_d = 8'h38; end
        S_DISP:  begin rs_d = 1'b0; data_d = 8'h0C; end
        S_ENTRY: begin rs_d = 1'b0; data_d = 8'h06; end
        S_CLR:   begin rs_d = 1'b0; data_d = 8'h01; end
        S_ADDR:  begin rs_d = 1'b0; data_d = addr_cmd(nrow); end
        S_DATA:  begin rs_d = 1'b1; data_d = rd_char; end
        default: ;
      endcase
  end

endmodule
